lpf_inverse: RTL and testbench

- Decoder for the two-tap sum filter stream y[n] = x[n] + x[n-1] (mod 2^width_p, history starting at 0).
- Reconstructs the original samples with x[n] = y[n] - x[n-1] (mod 2^width_p).
- Sits downstream of the sum filter, e.g. on loopback and reconstruction paths.
- Valid/ready on both sides; a 2-entry output skid buffer gives full throughput with a registered ready_o.

---
 rtl/lpf_pkg.sv | 10 +
 rtl/skid_buffer.sv | 67 ++++++
 rtl/lpf_inverse.sv | 64 ++++++
 tb/tb_lpf_inverse.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpf_pkg.sv
// Shared definitions for the two-tap sum filter and its inverse.
// Both ends take their initial history from here so they start in step.
package lpf_pkg;

    localparam int SAMPLE_W_C   = 8;
    localparam int HIST_RESET_C = 0;

    typedef logic [SAMPLE_W_C-1:0] sample_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry output buffer: main register plus one skid slot.
// ready_o is registered and drops exactly when the skid slot fills.
module skid_buffer #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               valid_o,
    input  logic               ready_i
);

    logic [width_p-1:0] main_q, main_d;
    logic [width_p-1:0] skid_q, skid_d;
    logic               main_v_q, main_v_d;
    logic               skid_v_q, skid_v_d;
    logic               rdy_q, rdy_d;
    logic               acc, drain;

    assign acc   = valid_i && rdy_q;
    assign drain = main_v_q && ready_i;

    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (drain && skid_v_q) begin
            // rdy_q is low whenever the skid is full, so no accept here
            main_d   = skid_q;
            skid_v_d = 1'b0;
        end else if (acc && (!main_v_q || drain)) begin
            main_d   = data_i;
            main_v_d = 1'b1;
        end else if (acc) begin
            skid_d   = data_i;
            skid_v_d = 1'b1;
        end else if (drain) begin
            main_v_d = 1'b0;
        end
        rdy_d = !skid_v_d;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            main_q   <= '0;
            main_v_q <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            main_q   <= main_d;
            main_v_q <= main_v_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
            rdy_q    <= rdy_d;
        end
    end

    assign ready_o = rdy_q;
    assign data_o  = main_q;
    assign valid_o = main_v_q;

endmodule

// File: rtl/lpf_inverse.sv
// Inverse of y[n] = x[n] + x[n-1]: recovers x[n] = y[n] - x[n-1].
// Subtractor, history and beat counter feed a two-entry skid buffer.
module lpf_inverse
    import lpf_pkg::*;
#(
    parameter int width_p     = 8,
    parameter int cnt_width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [width_p-1:0]     data_i,
    input  logic                   valid_i,
    input  logic                   restart_i,
    output logic                   ready_o,
    output logic [width_p-1:0]     data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [cnt_width_p-1:0] count_o
);

    logic [width_p-1:0]     hist_q, hist_d;
    logic [cnt_width_p-1:0] cnt_q, cnt_d;
    logic [width_p-1:0]     x;
    logic                   acc;

    assign acc = valid_i && ready_o;
    assign x   = data_i - (restart_i ? '0 : hist_q);

    always_comb begin
        hist_d = hist_q;
        cnt_d  = cnt_q;
        if (acc) begin
            hist_d = x;
            cnt_d  = restart_i ? cnt_width_p'(1)
                               : cnt_q + cnt_width_p'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hist_q <= width_p'(HIST_RESET_C);
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
        end
    end

    assign count_o = cnt_q;

    skid_buffer #(
        .width_p (width_p)
    ) u_skid (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (x),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i)
    );

endmodule

// File: tb/tb_lpf_inverse.sv
// Self-checking bench for lpf_inverse: directed scenarios plus a
// randomised encode/decode round trip through a scoreboard.
module tb_lpf_inverse;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        restart_i;
    logic        ready_o;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] count_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  sb[$];
    logic [7:0]  mhist = 8'd0;
    logic [15:0] mcnt  = 16'd0;
    logic        rt_mode = 1'b0;
    logic [7:0]  rt_x = 8'd0;
    int          rt_outs = 0;

    always #5 clk_i = ~clk_i;

    lpf_inverse #(
        .width_p     (8),
        .cnt_width_p (16)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .restart_i (restart_i),
        .ready_o   (ready_o),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .count_o   (count_o)
    );

    // Scoreboard: handshakes take effect at the next posedge,
    // so both sides are observed on the preceding negedge.
    always @(negedge clk_i) begin
        logic [7:0] exp_v;
        logic [7:0] mx;
        if (reset_n_i) begin
            if (valid_o && ready_i) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_out: got %0d, expected none pending",
                             data_o);
                end else begin
                    exp_v = sb.pop_front();
                    if (data_o !== exp_v) begin
                        failures++;
                        $display("FAIL sb_out: got %0d, expected %0d",
                                 data_o, exp_v);
                    end
                end
                if (rt_mode) rt_outs++;
            end
            if (valid_i && ready_o) begin
                mx    = data_i - (restart_i ? 8'd0 : mhist);
                mhist = mx;
                mcnt  = restart_i ? 16'd1 : mcnt + 16'd1;
                sb.push_back(rt_mode ? rt_x : mx);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present one beat and hold it until it is accepted.
    task automatic send(input logic [7:0] y, input logic r);
        int  n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        data_i    = y;
        restart_i = r;
        valid_i   = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk_i);
            acc = ready_o;
            n++;
            @(posedge clk_i);
        end
        #1;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: ready_o=%b, expected 1", ready_o);
        end
    endtask

    task automatic chk_out(input string nm, input logic [7:0] e);
        checks++;
        if (valid_o !== 1'b1 || data_o !== e) begin
            failures++;
            $display("FAIL %s: valid_o=%b data_o=%0d, expected 1/%0d",
                     nm, valid_o, data_o, e);
        end
    endtask

    task automatic chk_cnt(input string nm, input logic [15:0] e);
        checks++;
        if (count_o !== e) begin
            failures++;
            $display("FAIL %s: count_o=%0d, expected %0d", nm, count_o, e);
        end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        valid_i   = 1'b0;
        restart_i = 1'b0;
        data_i    = 8'd0;
        ready_i   = 1'b0;
        #12;
        checks++;
        if ({valid_o, ready_o} !== 2'b00 || data_o !== 8'd0 ||
            count_o !== 16'd0) begin
            failures++;
            $display("FAIL reset_vals: v=%b r=%b d=%0d c=%0d, expected 0s",
                     valid_o, ready_o, data_o, count_o);
        end
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_rdy_pre: ready_o=%b, expected 0", ready_o);
        end
        step();
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_rdy_post: ready_o=%b, expected 1", ready_o);
        end
    endtask

    task automatic test_basic();
        ready_i = 1'b1;
        send(8'd3, 1'b0);
        chk_out("basic0", 8'd3);
        send(8'd7, 1'b0);
        chk_out("basic1", 8'd4);
        send(8'd12, 1'b0);
        chk_out("basic2", 8'd8);
        send(8'd20, 1'b0);
        chk_out("basic3", 8'd12);
        valid_i = 1'b0;
        step();
        chk_cnt("basic_cnt", 16'd4);
        step();
    endtask

    task automatic test_wrap();
        ready_i = 1'b1;
        send(8'd200, 1'b1);
        chk_out("wrap0", 8'd200);
        send(8'd100, 1'b0);
        chk_out("wrap1", 8'd156);
        send(8'd1, 1'b1);
        chk_out("wrap2", 8'd1);
        send(8'd0, 1'b0);
        chk_out("wrap3", 8'd255);
        valid_i = 1'b0;
        step();
        step();
    endtask

    task automatic test_backpressure();
        ready_i   = 1'b0;
        data_i    = 8'd5;
        restart_i = 1'b1;
        valid_i   = 1'b1;
        step();
        chk_out("bp_first", 8'd5);
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_rdy1: ready_o=%b, expected 1", ready_o);
        end
        data_i    = 8'd6;
        restart_i = 1'b0;
        step();
        checks++;
        if (ready_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_rdy0: ready_o=%b, expected 0", ready_o);
        end
        data_i = 8'd7;
        step();
        chk_out("bp_hold1", 8'd5);
        step();
        chk_out("bp_hold2", 8'd5);
        chk_cnt("bp_cnt", 16'd2);
        ready_i = 1'b1;
        step();
        chk_out("bp_out1", 8'd1);
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_rdy_back: ready_o=%b, expected 1", ready_o);
        end
        step();
        chk_out("bp_out2", 8'd6);
        valid_i = 1'b0;
        step();
        checks++;
        if (valid_o !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL bp_drain: valid_o=%b pending=%0d, expected 0/0",
                     valid_o, sb.size());
        end
    endtask

    task automatic test_restart();
        ready_i = 1'b1;
        send(8'd10, 1'b1);
        chk_out("rs0", 8'd10);
        send(8'd15, 1'b0);
        chk_out("rs1", 8'd5);
        send(8'd50, 1'b1);
        chk_out("rs2", 8'd50);
        chk_cnt("rs_cnt1", 16'd1);
        send(8'd53, 1'b0);
        chk_out("rs3", 8'd3);
        chk_cnt("rs_cnt2", 16'd2);
        valid_i = 1'b0;
        step();
        step();
    endtask

    task automatic test_async_reset();
        ready_i = 1'b0;
        send(8'd4, 1'b1);
        send(8'd8, 1'b0);
        valid_i = 1'b0;
        #2;
        reset_n_i = 1'b0;
        sb.delete();
        mhist = 8'd0;
        mcnt  = 16'd0;
        #1;
        checks++;
        if ({valid_o, ready_o} !== 2'b00 || count_o !== 16'd0) begin
            failures++;
            $display("FAIL arst: v=%b r=%b c=%0d, expected 0/0/0",
                     valid_o, ready_o, count_o);
        end
        #10;
        reset_n_i = 1'b1;
        step();
        ready_i = 1'b1;
        send(8'd9, 1'b0);
        chk_out("arst_first", 8'd9);
        valid_i = 1'b0;
        step();
        step();
    endtask

    task automatic test_round_trip();
        logic [7:0] x;
        logic [7:0] prev;
        logic [7:0] y;
        logic       acc;
        int         n;
        bit         stop;
        prev    = 8'd0;
        stop    = 1'b0;
        rt_mode = 1'b1;
        rt_outs = 0;
        for (int i = 0; i < 10000 && !stop; i++) begin
            x    = 8'($urandom);
            y    = x + prev;
            prev = x;
            while ($urandom_range(0, 3) == 0) begin
                valid_i = 1'b0;
                ready_i = 1'($urandom_range(0, 1));
                step();
            end
            data_i    = y;
            restart_i = (i == 0);
            rt_x      = x;
            valid_i   = 1'b1;
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 200) begin
                ready_i = ($urandom_range(0, 2) != 0);
                @(negedge clk_i);
                acc = ready_o;
                n++;
                step();
            end
            if (!acc) begin
                checks++;
                failures++;
                $display("FAIL rt_timeout: beat %0d never accepted", i);
                stop = 1'b1;
            end
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int k = 0; k < 50 && (sb.size() != 0 || valid_o); k++)
            step();
        checks++;
        if (sb.size() != 0 || rt_outs != 10000) begin
            failures++;
            $display("FAIL rt_total: outs=%0d pending=%0d, expected 10000/0",
                     rt_outs, sb.size());
        end
        rt_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_restart();
        test_async_reset();
        test_round_trip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
